// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blink arbiter: FSM state encoding,
// board clock constants and the fixed-priority one-hot picker.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_e;

    localparam int CLK_HZ         = 25000000;
    localparam int TICK_DIV_100MS = 2500000;

    // Requester vectors are zero-extended to this width; NREQ must not exceed it.
    localparam int PRIO_W = 32;

    // Isolates the lowest set bit: index 0 has the highest priority.
    function automatic logic [PRIO_W-1:0] prio_onehot(input logic [PRIO_W-1:0] v);
        return v & (~v + PRIO_W'(1));
    endfunction

endpackage

// File: rtl/led_blink_arbiter_tick_gen.sv
// Prescaler for the blink sequencer: divides clk into one-cycle ticks and can
// be restarted synchronously so a new sequence starts on an exact tick boundary.
module led_tick_gen #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick     = (cnt == LAST);
    // One cycle ahead of tick, so registered outputs can land on the tick cycle.
    assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/led_blink_arbiter.sv
// Fixed-priority, non-preemptive arbiter that lets several status sources share
// one LED, each showing its code as N flashes followed by a dark gap.
module led_blink_arbiter
    import led_pkg::*;
#(
    parameter int TICK_DIV  = 2500000,
    parameter int NREQ      = 4,
    parameter int CODE_W    = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 3,
    parameter int GAP_TICKS = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CODE_W-1:0]   code,
    output logic                     led,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     done
);

    localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_TICKS  = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
    localparam int PH_W       = $clog2(MAX_TICKS + 1);

    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

    led_state_e          state, state_next;
    logic [PH_W-1:0]     phase, phase_d, phase_last;
    logic [CODE_W-1:0]   pulse, pulse_d;
    logic                led_d, busy_d, done_d;
    logic [NREQ-1:0]     grant_d;
    logic [NREQ-1:0]     valid, sel;
    logic [CODE_W-1:0]   sel_code;
    logic                start, tick, pre_tick, phase_end;

    // A zero code is treated as no request at all.
    always_comb begin
        valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            valid[i] = req[i] && (code[i*CODE_W +: CODE_W] != '0);
        end
    end

    assign sel   = NREQ'(prio_onehot(PRIO_W'(valid)));
    assign start = (state == ST_IDLE) && (valid != '0);

    always_comb begin
        sel_code = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel[i]) sel_code |= code[i*CODE_W +: CODE_W];
        end
    end

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        case (state)
            ST_ON:   phase_last = ON_LAST;
            ST_OFF:  phase_last = OFF_LAST;
            ST_GAP:  phase_last = GAP_LAST;
            default: phase_last = '0;
        endcase
    end

    assign phase_end = tick && (phase == phase_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            phase <= '0;
            pulse <= '0;
            led   <= 1'b0;
            grant <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            phase <= phase_d;
            pulse <= pulse_d;
            led   <= led_d;
            grant <= grant_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_ON;
            ST_ON:   if (phase_end) state_next = ST_OFF;
            ST_OFF:  if (phase_end) state_next = (pulse != '0) ? ST_ON : ST_GAP;
            ST_GAP:  if (phase_end) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        phase_d = phase;
        pulse_d = pulse;
        led_d   = led;
        grant_d = grant;
        busy_d  = busy;
        done_d  = 1'b0;
        if ((state != ST_IDLE) && tick) begin
            phase_d = phase_end ? '0 : phase + PH_W'(1);
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pulse_d = sel_code;
                    grant_d = sel;
                    busy_d  = 1'b1;
                    led_d   = 1'b1;
                    phase_d = '0;
                end
            end
            ST_ON: begin
                if (phase_end) begin
                    pulse_d = pulse - CODE_W'(1);
                    led_d   = 1'b0;
                end
            end
            ST_OFF: begin
                if (phase_end) led_d = (pulse != '0);
            end
            ST_GAP: begin
                done_d = pre_tick && (phase == GAP_LAST);
                if (phase_end) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter at TICK_DIV=4: per-cycle comparison against a
// time-offset reference model, table-driven sequences and hand-written corners.
module tb_led_blink_arbiter;

    localparam int TD   = 4;
    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int ON   = 2;
    localparam int OFF  = 3;
    localparam int GAP  = 10;
    localparam int PER  = (ON + OFF) * TD;
    localparam int LOGN = 8192;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*CW-1:0] code = '0;
    logic            led, busy, done;
    logic [NREQ-1:0] grant;

    led_blink_arbiter #(
        .TICK_DIV(TD), .NREQ(NREQ), .CODE_W(CW),
        .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .code  (code),
        .led   (led),
        .grant (grant),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic            log_led   [LOGN];
    logic            log_done  [LOGN];
    logic [NREQ-1:0] log_grant [LOGN];

    // Reference model: a sequence is described only by its owner, its code and
    // the number of cycles elapsed since the first granted cycle.
    bit m_active = 1'b0;
    int m_owner  = 0;
    int m_code   = 0;
    int m_t      = 0;

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*CW-1:0] code;
        int                 chg_at;
        logic [NREQ-1:0]    req2;
        logic [NREQ*CW-1:0] code2;
        int                 owner;
        int                 flashes;
    } vec_t;

    vec_t tbl[5];

    function automatic int seq_len(int c);
        return c * PER + GAP * TD;
    endfunction

    function automatic int count_flashes(int from, int to);
        int n = 0;
        for (int k = from; k <= to; k++) begin
            if (log_led[k] && !log_led[k-1]) n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock; the model decides from the inputs present this cycle.
    task automatic step();
        int  pick;
        bit  found;
        bit  exp_led, exp_done;
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_t++;
            if (m_t == seq_len(m_code)) m_active = 1'b0;
        end else begin
            found = 1'b0;
            pick  = 0;
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req[i] && (code[i*CW +: CW] != 0)) begin
                    found = 1'b1;
                    pick  = i;
                end
            end
            if (found) begin
                m_active = 1'b1;
                m_owner  = pick;
                m_code   = int'(code[pick*CW +: CW]);
                m_t      = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < LOGN) begin
            log_led[cyc]   = led;
            log_done[cyc]  = done;
            log_grant[cyc] = grant;
        end
        exp_led  = m_active && (m_t < m_code * PER) && ((m_t % PER) < ON * TD);
        exp_done = m_active && (m_t == seq_len(m_code) - 1);
        check("led",   32'(led),   32'(exp_led));
        check("done",  32'(done),  32'(exp_done));
        check("busy",  32'(busy),  32'(m_active));
        check("grant", 32'(grant), m_active ? (32'd1 << m_owner) : 32'd0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000 && busy; k++) step();
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic rst_pulse(input int cycles);
        rst_n    = 1'b0;
        m_active = 1'b0;
        #1;
        check("async_rst_led",   32'(led),   32'd0);
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_busy",  32'(busy),  32'd0);
        check("async_rst_done",  32'(done),  32'd0);
        for (int k = 0; k < cycles; k++) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int g, g2, len;
        log_led[0] = 1'b0; log_done[0] = 1'b0; log_grant[0] = '0;

        tbl[0] = '{4'b0100, 16'h0200, 78, 4'b0000, 16'h0200, 2, 2};
        tbl[1] = '{4'b0110, 16'h0200, 3,  4'b0010, 16'h0200, 2, 2};
        tbl[2] = '{4'b0001, 16'h0003, 2,  4'b0001, 16'h0001, 0, 3};
        tbl[3] = '{4'b1000, 16'hF000, 1,  4'b1000, 16'hF000, 3, 15};
        tbl[4] = '{4'b1111, 16'h4321, 1,  4'b1111, 16'h1234, 0, 1};

        // Reset, then a long idle stretch with a reset pulse in the middle.
        for (int k = 0; k < 3; k++) step();
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) step();
        rst_pulse(2);
        for (int k = 0; k < 50; k++) step();

        for (int v = 0; v < 5; v++) begin
            wait_idle();
            len  = seq_len(tbl[v].flashes);
            req  = tbl[v].req;
            code = tbl[v].code;
            g    = cyc + 1;
            while (cyc < g + tbl[v].chg_at) step();
            req  = tbl[v].req2;
            code = tbl[v].code2;
            while (cyc < g + len - 1) step();
            req = '0;
            step();
            check("tbl_grant_before", 32'(log_grant[g-1]), 32'd0);
            check("tbl_grant",        32'(log_grant[g]),   32'd1 << tbl[v].owner);
            check("tbl_led_first",    32'(log_led[g]),     32'd1);
            check("tbl_flashes",      32'(count_flashes(g, g + len - 1)), 32'(tbl[v].flashes));
            check("tbl_done_early",   32'(log_done[g+len-2]), 32'd0);
            check("tbl_done",         32'(log_done[g+len-1]), 32'd1);
            check("tbl_grant_after",  32'(log_grant[g+len]),  32'd0);
            if (v == 0) begin
                check("c2_led_g7",  32'(log_led[g+7]),  32'd1);
                check("c2_led_g8",  32'(log_led[g+8]),  32'd0);
                check("c2_led_g19", 32'(log_led[g+19]), 32'd0);
                check("c2_led_g20", 32'(log_led[g+20]), 32'd1);
                check("c2_led_g27", 32'(log_led[g+27]), 32'd1);
                check("c2_led_g28", 32'(log_led[g+28]), 32'd0);
                check("c2_led_g79", 32'(log_led[g+79]), 32'd0);
            end
        end

        // Priority and non-preemption: req[0] arrives while req[3] is running.
        wait_idle();
        req  = 4'b1000;
        code = 16'h1000;
        g    = cyc + 1;
        while (cyc < g + 5) step();
        req  = 4'b1001;
        code = 16'h1003;
        while (cyc < g + 61) step();
        g2 = g + 61;
        step();
        req = '0;
        while (cyc < g2 + seq_len(3)) step();
        check("prio_first_grant",   32'(log_grant[g]),    32'b1000);
        check("prio_first_flashes", 32'(count_flashes(g, g + 59)), 32'd1);
        check("prio_first_done",    32'(log_done[g+59]),  32'd1);
        check("prio_idle_gap",      32'(log_grant[g+60]), 32'd0);
        check("prio_second_grant",  32'(log_grant[g2]),   32'b0001);
        check("prio_second_flashes", 32'(count_flashes(g2, g2 + 99)), 32'd3);
        check("prio_second_done",   32'(log_done[g2+99]), 32'd1);

        // Reset mid-flash, then re-grant with the request still held.
        wait_idle();
        req  = 4'b0001;
        code = 16'h0002;
        g    = cyc + 1;
        while (cyc < g + 10) step();
        #1;
        rst_pulse(3);
        step();
        check("regrant", 32'(grant), 32'b0001);
        check("regrant_led", 32'(led), 32'd1);
        req = '0;
        wait_idle();

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                req = NREQ'($urandom_range(0, 15));
                for (int i = 0; i < NREQ; i++) code[i*CW +: CW] = CW'($urandom_range(0, 3));
            end
            step();
        end
        req = '0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares the single board test LED between up to NREQ status sources, each signalling a small numeric code as a burst of blinks (code N = N flashes, then a gap). The block is a fixed-priority, non-preemptive arbiter plus blink sequencer. It sits between the status logic and the LED pin, where the free-running blink counter used to drive it. Timing is derived from the 25 MHz system clock through an internal tick prescaler.

## Interface
- TICK_DIV, default 2500000: clk cycles per tick (100 ms at 25 MHz); must be ≥ 2.
- NREQ, default 4: number of requesters; must be ≥ 1.
- CODE_W, default 4: width of each blink code.
- ON_TICKS, default 2: LED-on duration per flash, in ticks; must be ≥ 1.
- OFF_TICKS, default 3: LED-off duration between flashes, in ticks; must be ≥ 1.
- GAP_TICKS, default 10: trailing dark gap after the last flash, in ticks; must be ≥ 1.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per source; level-sensitive.
- code  in  NREQ*CODE_W  blink code for source i in bits [i*CODE_W +: CODE_W].
- led  out  1  LED drive, active high.
- grant  out  NREQ  one-hot owner of the current sequence; all zero when idle.
- busy  out  1  high while a sequence is in progress.
- done  out  1  single-cycle pulse on the last cycle of a sequence.

## Operation
- All outputs are registered. Reset values: led=0, grant=0, busy=0, done=0, state=IDLE, all counters 0.
- States are IDLE, ON, OFF and GAP.
- IDLE:
  - Each cycle, find the lowest index i with req[i]=1 and code_i ≠ 0. A zero code counts as no request.
  - If one exists, latch code_i into the pulse counter and set grant to one-hot i, with busy=1 and led=1.
  - Restart the prescaler and phase counter, then go to ON.
- ON: led=1. After ON_TICKS ticks, decrement the pulse counter and go to OFF.
- OFF: led=0. After OFF_TICKS ticks, go to ON if the pulse counter is non-zero, otherwise go to GAP.
- GAP: led=0. On the last cycle of GAP_TICKS ticks, done=1. Next cycle: IDLE, with grant=0 and busy=0.
- Non-preemptive rules:
  - Dropping req, changing code, or a higher-priority request arriving mid-sequence has no effect on the running sequence.
  - The code is sampled only at grant.
- The same requester may be re-granted immediately if it still requests in IDLE. There is no fairness guarantee; priority is strictly by index.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; a tick is the wrap cycle.
  - It is forced to 0 on grant, so every phase is an exact multiple of TICK_DIV cycles.
- Width rules:
  - Prescaler is $clog2(TICK_DIV) bits.
  - Phase counter is $clog2 of max(ON_TICKS, OFF_TICKS, GAP_TICKS)+1 bits.
  - Pulse counter is CODE_W bits.
  - No counter may wrap within a phase.
- Reset mid-sequence: outputs return to reset values immediately (asynchronous), and no done pulse is issued.

## Timing
- Let R be the cycle in which IDLE sees a valid request. Let G = R+1 be the first cycle with grant≠0, busy=1 and led=1.
- Sequence length is code×(ON_TICKS+OFF_TICKS)×TICK_DIV + GAP_TICKS×TICK_DIV cycles, counted from G.
  - done is asserted on the last cycle of that span; IDLE follows the next cycle.
- Minimum spacing between consecutive grants is sequence length + 1 cycle (one IDLE cycle).
- Flash k (k = 0..code-1):
  - led high from G + k·(ON+OFF)·TICK_DIV for ON·TICK_DIV cycles;
  - then low for OFF·TICK_DIV cycles.

## Structure
- Package led_pkg holds:
  - the state enum (IDLE, ON, OFF, GAP);
  - default constants CLK_HZ=25000000 and TICK_DIV_100MS=2500000;
  - a function returning the priority one-hot of a request vector.
- Sub-module led_tick_gen contains the prescaler and tick pulse, with a sync clear input driven at grant. The FSM, counters and arbitration stay in led_blink_arbiter.

## Test plan
All scenarios use TICK_DIV=4 with the other parameters at their defaults unless stated.
- Reset then idle: hold req=0 for 100 cycles. led=0, grant=0, busy=0 and done=0 throughout; asserting rst_n mid-run keeps them 0.
- Single code: req[2]=1, code2=2 sampled at R.
  - grant=4'b0100 from G=R+1.
  - led high on G..G+7, low on G+8..G+19, high on G+20..G+27, low on G+28..G+79.
  - done only at G+79; grant=0 at G+80.
- Priority and non-preemption:
  - req[3] (code 1) is granted first. req[0] (code 3) is raised at G+5 and stays high.
  - req[3]'s sequence completes unchanged, done at G+59.
  - grant=4'b0001 at G+61 and led shows 3 flashes.
- Zero code and withdrawal:
  - req[1]=1 with code1=0 is never granted.
  - req[2] (code 2) dropping req at G+3 still yields 2 flashes and done.
- Code latch: changing code0 from 3 to 1 at G+2 still yields 3 flashes.
- Reset mid-flash: pull rst_n low at G+10 → led, grant and busy are 0 asynchronously and no done; after release, with req still held, the block re-grants one cycle after the first IDLE cycle.
